data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-port arbiter and access sequencer in front of the single-ported data memory. It shares the memory between requester 0 (load/store stage) and requester 1 (debug/DMA loader). It generates the memory's MemRead/MemWrite strobes with the memory's registered-read timing. It returns read data through a held result register, and rejects out-of-range addresses without touching the memory.

## Interface
- WIDTH, 32, data and address width
- DEPTH, 512, number of memory words; a valid address is below DEPTH
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  request, held high with fields stable until done
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  WIDTH  word address
- wdata0 / wdata1  in  WIDTH  write data
- done0 / done1  out  1  one-cycle completion pulse, registered
- err  out  1  valid with a done pulse; 1 = address was out of range
- rdata  out  WIDTH  last completed read data, held until the next read completes
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_addr  out  WIDTH  to memory Address
- mem_wdata  out  WIDTH  to memory WriteData
- mem_rdata  in  WIDTH  from memory ReadData; only valid while mem_read is high

## Operation
- FSM states: IDLE, WR, RD1, RD2, RESP.
- **IDLE:**
  - Arbitrate among asserted requests.
  - On a grant, latch the port id, we, addr and wdata into internal registers.
  - Next state:
    - addr ≥ DEPTH → RESP with err=1.
    - we=1 → WR.
    - we=0 → RD1.
  - No request → stay in IDLE.
- **WR:** mem_write=1, mem_addr and mem_wdata from the latched values. The memory writes at the end of this cycle. Next state RESP.
- **RD1:** mem_read=1. The memory captures the word at the end of this cycle. Next state RD2.
- **RD2:** mem_read=1 is held so that mem_rdata is driven. Load rdata from mem_rdata at the end of this cycle. Next state RESP.
- **RESP:**
  - done of the granted port = 1.
  - err = latched range flag; err=0 on success.
  - Next state IDLE.
- **Outside RESP:** done0, done1 and err are 0.
- **Memory-side idle values:** mem_read and mem_write are 0 outside their states. mem_addr and mem_wdata hold their last values; they are never Z.
- **rdata:** changes only at a successful read's RD2 edge. Writes and errors leave it unchanged.
- **Requester rule:** a requester may change its fields or drop req in the cycle after its done. If it keeps req high in IDLE, that is a new request.
- **Dropping req:** dropping req before done is illegal. The in-flight access still completes and done still pulses.

## Timing
- **Reset values:** state IDLE, done0=done1=0, err=0, rdata=0, mem_read=mem_write=0, mem_addr=mem_wdata=0, round-robin pointer favours port 0.
- **Latency,** counted from the IDLE cycle in which the request is sampled (cycle 0):
  - write: done in cycle 2;
  - read: done in cycle 3, with rdata valid in the same cycle;
  - range error: done in cycle 1.
- **Throughput:** one IDLE cycle between accesses. A back-to-back write costs 3 cycles per access; a read costs 4.
- **Simultaneous requests:** handled per the Configuration section. A loser keeps waiting with no time-out.
- **Reset mid-operation:**
  - The FSM returns to IDLE and no done is issued.
  - If reset coincides with the WR cycle, mem_write is already high at that edge, so the memory write takes effect.
  - The read state is discarded, and rdata is cleared.
- **Address boundaries:** addr = DEPTH−1 is valid. addr = DEPTH and all larger addresses, including all-ones, set err.

## Configuration
- **ARB_ROUND_ROBIN_EN defined:**
  - When both ports request in IDLE, the port not granted most recently wins.
  - The pointer updates on every grant, error grants included.
  - A single requester is always granted.
- **ARB_ROUND_ROBIN_EN undefined:**
  - Fixed priority, port 0 always wins.
  - Port 1 can be starved.
  - The pointer logic is absent.

## Test plan
- **Port-0 write then read:** port 0 writes 0xDEADBEEF to addr 5 and gets done0 in cycle 2. It then reads addr 5 and gets done0 in cycle 3 with rdata=0xDEADBEEF and err=0.
- **Mixed simultaneous requests:** both ports request in the same cycle; port 0 reads addr 7, port 1 writes 0x1234 to addr 9.
  - With ARB_ROUND_ROBIN_EN, the grant order alternates port 0, port 1, port 0 across three contested rounds.
  - Without it, port 0 is served three times before port 1.
- **Out-of-range read:** a read of addr 512 gives done in cycle 1 with err=1. mem_read and mem_write stay 0, and rdata is unchanged.
- **Boundary write:** a write to addr 511 succeeds. A read of 511 then returns the written value.
- **Reset during read:** reset is asserted during RD2. The outputs go to their reset values on the next cycle, no done pulses, and a following read completes normally.
- **Strobe-only-while-granted:** while the FSM is in RD1/RD2, any change on the non-granted port's fields has no effect on mem_addr. mem_read is high for exactly 2 cycles per read.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// Requester handshake and data-memory bus bundle for data_mem_arbiter.
interface data_mem_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0;
    logic             req1;
    logic             we0;
    logic             we1;
    logic [WIDTH-1:0] addr0;
    logic [WIDTH-1:0] addr1;
    logic [WIDTH-1:0] wdata0;
    logic [WIDTH-1:0] wdata1;
    logic             done0;
    logic             done1;
    logic             err;
    logic [WIDTH-1:0] rdata;
    logic             mem_read;
    logic             mem_write;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1,
        input  addr0, addr1, wdata0, wdata1,
        input  mem_rdata,
        output done0, done1, err, rdata,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1,
        output addr0, addr1, wdata0, wdata1,
        output mem_rdata,
        input  done0, done1, err, rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter/sequencer for the single-ported data memory.
// Define ARB_ROUND_ROBIN_EN for round-robin; otherwise port 0 has fixed priority.
module data_mem_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 512
) (
    input  logic              clk,
    input  logic              reset,
    data_mem_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD1,
        RD2,
        RESP
    } state_t;

    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(DEPTH);

    state_t           state;
    logic             port_q;
    logic             done0_q;
    logic             done1_q;
    logic             err_q;
    logic [WIDTH-1:0] rdata_q;
    logic             mem_read_q;
    logic             mem_write_q;
    logic [WIDTH-1:0] mem_addr_q;
    logic [WIDTH-1:0] mem_wdata_q;

    logic             g_req;
    logic             g_port;
    logic             g_we;
    logic [WIDTH-1:0] g_addr;
    logic [WIDTH-1:0] g_wdata;
    logic             g_oor;

`ifdef ARB_ROUND_ROBIN_EN
    // rr_ptr=1 means port 1 wins the next contested grant
    logic rr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (state == IDLE && g_req) begin
            rr_ptr <= ~g_port;
        end
    end

    assign g_port = bus.req1 & (~bus.req0 | rr_ptr);
`else
    assign g_port = bus.req1 & ~bus.req0;
`endif

    always_comb begin
        g_req   = bus.req0 | bus.req1;
        g_we    = g_port ? bus.we1    : bus.we0;
        g_addr  = g_port ? bus.addr1  : bus.addr0;
        g_wdata = g_port ? bus.wdata1 : bus.wdata0;
        g_oor   = (g_addr >= LIMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            port_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err_q   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (g_req) begin
                        port_q <= g_port;
                        // rejected accesses never drive the memory bus
                        if (g_oor) begin
                            state   <= RESP;
                            done0_q <= ~g_port;
                            done1_q <= g_port;
                            err_q   <= 1'b1;
                        end else if (g_we) begin
                            state       <= WR;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= g_addr;
                            mem_wdata_q <= g_wdata;
                        end else begin
                            state      <= RD1;
                            mem_read_q <= 1'b1;
                            mem_addr_q <= g_addr;
                        end
                    end
                end
                WR: begin
                    mem_write_q <= 1'b0;
                    state       <= RESP;
                    done0_q     <= ~port_q;
                    done1_q     <= port_q;
                end
                RD1: begin
                    state <= RD2;
                end
                RD2: begin
                    mem_read_q <= 1'b0;
                    rdata_q    <= bus.mem_rdata;
                    state      <= RESP;
                    done0_q    <= ~port_q;
                    done1_q    <= port_q;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: memory model, timeline reference model,
// per-cycle compare and directed scenarios.
module tb_data_mem_arbiter;
    localparam int K_ERR = 0;
    localparam int K_WR  = 1;
    localparam int K_RD  = 2;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    data_mem_arbiter_if #(.WIDTH(32)) bus ();

    data_mem_arbiter #(.WIDTH(32), .DEPTH(512)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory with registered read: word captured while mem_read is high
    logic [31:0] mem     [512];
    logic [31:0] ref_mem [512];
    logic [31:0] mem_q;

    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr[8:0]] <= bus.mem_wdata;
        if (bus.mem_read) mem_q <= mem[bus.mem_addr[8:0]];
    end

    assign bus.mem_rdata = bus.mem_read ? mem_q : 32'h0;

    task automatic chk1(input string name, input logic a, input logic e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, a, e, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] a,
                         input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, a, e, $time);
        end
    endtask

    // Reference model: one transaction at a time, outputs derived from
    // offset since the grant cycle.
    int          cyc;
    int          t0;
    int          kind;
    int          lat_m;
    logic        act;
    logic        mvalid;
    logic        mport;
    logic        last;
    logic [31:0] maddr;
    logic [31:0] mdata;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;

    initial begin
        cyc    = 0;
        act    = 1'b0;
        mvalid = 1'b0;
        last   = 1'b1;
    end

    always @(negedge clk) begin
        int   d;
        logic e_d0, e_d1, e_err, e_rd, e_wr;
        cyc++;
        e_d0 = 1'b0;
        e_d1 = 1'b0;
        e_err = 1'b0;
        e_rd = 1'b0;
        e_wr = 1'b0;
        if (mvalid) begin
            if (act) begin
                d = cyc - t0;
                if (d == 1 && kind != K_ERR) e_addr = maddr;
                if (kind == K_WR && d == 1) begin
                    e_wr = 1'b1;
                    e_wdata = mdata;
                end
                if (kind == K_RD && (d == 1 || d == 2)) e_rd = 1'b1;
                if (kind == K_RD && d == 3) e_rdata = mdata;
                if (d == lat_m) begin
                    e_d0 = ~mport;
                    e_d1 = mport;
                    e_err = (kind == K_ERR);
                end
            end
            chk1("done0", bus.done0, e_d0);
            chk1("done1", bus.done1, e_d1);
            chk1("err", bus.err, e_err);
            chk1("mem_read", bus.mem_read, e_rd);
            chk1("mem_write", bus.mem_write, e_wr);
            chk32("mem_addr", bus.mem_addr, e_addr);
            chk32("mem_wdata", bus.mem_wdata, e_wdata);
            chk32("rdata", bus.rdata, e_rdata);
        end
        if (reset) begin
            mvalid  = 1'b1;
            act     = 1'b0;
            e_addr  = 32'h0;
            e_wdata = 32'h0;
            e_rdata = 32'h0;
            last    = 1'b1;
        end else if (mvalid) begin
            if (act) begin
                if (cyc - t0 == lat_m) act = 1'b0;
            end else if (bus.req0 || bus.req1) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (bus.req0 && bus.req1) mport = ~last;
                else mport = bus.req1;
`else
                mport = ~bus.req0;
`endif
                maddr = mport ? bus.addr1 : bus.addr0;
                if (maddr >= 32'd512) begin
                    kind  = K_ERR;
                    lat_m = 1;
                end else if (mport ? bus.we1 : bus.we0) begin
                    kind  = K_WR;
                    lat_m = 2;
                    mdata = mport ? bus.wdata1 : bus.wdata0;
                    ref_mem[maddr[8:0]] = mdata;
                end else begin
                    kind  = K_RD;
                    lat_m = 3;
                    mdata = ref_mem[maddr[8:0]];
                end
                t0   = cyc;
                act  = 1'b1;
                last = mport;
            end
        end
    end

    task automatic do_req(input logic p, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output logic e);
        @(posedge clk);
        #1;
        if (p) begin
            bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; bus.req1 = 1'b1;
        end else begin
            bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; bus.req0 = 1'b1;
        end
        lat = -1;
        e = 1'bx;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if ((p ? bus.done1 : bus.done0) === 1'b1) begin
                lat = c;
                e = bus.err;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (p) bus.req1 = 1'b0;
        else bus.req0 = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic e;
        int   nrd;
        int   n;
        int   order[3];
        logic got1;
        tests = 0;
        fails = 0;
        for (int i = 0; i < 512; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        reset = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.we0 = 1'b0; bus.we1 = 1'b0;
        bus.addr0 = 32'h0; bus.addr1 = 32'h0;
        bus.wdata0 = 32'h0; bus.wdata1 = 32'h0;
        do_reset();
        chk1("rst_done0", bus.done0, 1'b0);
        chk1("rst_done1", bus.done1, 1'b0);
        chk1("rst_mem_read", bus.mem_read, 1'b0);
        chk1("rst_mem_write", bus.mem_write, 1'b0);
        chk32("rst_rdata", bus.rdata, 32'h0);
        chk32("rst_mem_addr", bus.mem_addr, 32'h0);

        do_req(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, lat, e);
        chk32("wr5_lat", lat, 32'd2);
        chk1("wr5_err", e, 1'b0);
        do_req(1'b0, 1'b0, 32'd5, 32'h0, lat, e);
        chk32("rd5_lat", lat, 32'd3);
        chk1("rd5_err", e, 1'b0);
        chk32("rd5_data", bus.rdata, 32'hDEADBEEF);

        do_req(1'b1, 1'b0, 32'd512, 32'h0, lat, e);
        chk32("oor512_lat", lat, 32'd1);
        chk1("oor512_err", e, 1'b1);
        chk32("oor512_rdata", bus.rdata, 32'hDEADBEEF);
        do_req(1'b0, 1'b1, 32'hFFFFFFFF, 32'h55, lat, e);
        chk32("oor_ones_lat", lat, 32'd1);
        chk1("oor_ones_err", e, 1'b1);

        do_req(1'b1, 1'b1, 32'd511, 32'hA5A55A5A, lat, e);
        chk32("wr511_lat", lat, 32'd2);
        chk1("wr511_err", e, 1'b0);
        do_req(1'b0, 1'b0, 32'd511, 32'h0, lat, e);
        chk32("rd511_lat", lat, 32'd3);
        chk32("rd511_data", bus.rdata, 32'hA5A55A5A);

        // non-granted port fields wiggle during a read
        @(posedge clk);
        #1;
        bus.we0 = 1'b0; bus.addr0 = 32'd7; bus.req0 = 1'b1;
        nrd = 0;
        lat = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.mem_read) nrd++;
            if (bus.done0) begin
                lat = c;
                break;
            end
            #1;
            bus.addr1 = $urandom;
            bus.wdata1 = $urandom;
            bus.we1 = c[0];
        end
        @(posedge clk);
        #1;
        bus.req0 = 1'b0;
        chk32("strobe_lat", lat, 32'd3);
        chk32("strobe_rd_cycles", nrd, 32'd2);

        do_req(1'b0, 1'b0, 32'd5, 32'h0, lat, e);
        chk32("pre_rst_data", bus.rdata, 32'hDEADBEEF);
        // reset lands on RD2
        @(posedge clk);
        #1;
        bus.we0 = 1'b0; bus.addr0 = 32'd5; bus.req0 = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.req0 = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk32("midrst_rdata", bus.rdata, 32'h0);
        chk1("midrst_mem_read", bus.mem_read, 1'b0);
        chk1("midrst_done0", bus.done0, 1'b0);
        do_req(1'b1, 1'b0, 32'd511, 32'h0, lat, e);
        chk32("postrst_lat", lat, 32'd3);
        chk32("postrst_data", bus.rdata, 32'hA5A55A5A);

        do_reset();
        @(posedge clk);
        #1;
        bus.we0 = 1'b0; bus.addr0 = 32'd7;
        bus.we1 = 1'b1; bus.addr1 = 32'd9; bus.wdata1 = 32'h1234;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        n = 0;
        order[0] = 9; order[1] = 9; order[2] = 9;
        for (int c = 0; c < 60 && n < 3; c++) begin
            @(negedge clk);
            if (bus.done0) begin
                order[n] = 0;
                n++;
            end else if (bus.done1) begin
                order[n] = 1;
                n++;
            end
        end
        chk32("mix_rounds", n, 32'd3);
`ifdef ARB_ROUND_ROBIN_EN
        chk32("mix_g0", order[0], 32'd0);
        chk32("mix_g1", order[1], 32'd1);
        chk32("mix_g2", order[2], 32'd0);
`else
        chk32("mix_g0", order[0], 32'd0);
        chk32("mix_g1", order[1], 32'd0);
        chk32("mix_g2", order[2], 32'd0);
`endif
        @(posedge clk);
        #1;
        bus.req0 = 1'b0;
        got1 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.done1) begin
                got1 = 1'b1;
                break;
            end
        end
        chk1("mix_p1_served", got1, 1'b1);
        @(posedge clk);
        #1;
        bus.req1 = 1'b0;
        do_req(1'b0, 1'b0, 32'd9, 32'h0, lat, e);
        chk32("rd9_data", bus.rdata, 32'h00001234);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
